// File: rtl/video_out_stage.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : video_out_stage
// Description : Video output stage. Expands colour to 8 bits per component,
//               applies per-line scanline darkening and regenerates DE.
//               All outputs leave two clocks after their inputs are sampled.
// Revision    : 1.0 - initial release
// ============================================================================
module video_out_stage #(
    parameter int CW        = 4,   // input bits per colour component, 1..8
    parameter int SL_PERIOD = 2    // lines per scanline group, 2 or 3
) (
    input  logic          clk_vid,
    input  logic          reset,
    input  logic          ce_pix,
    input  logic [CW-1:0] R,
    input  logic [CW-1:0] G,
    input  logic [CW-1:0] B,
    input  logic          HSync,
    input  logic          VSync,
    input  logic          HBlank,
    input  logic          VBlank,
    input  logic [2:0]    sl_level,
    input  logic [1:0]    sl_phase,
    output logic          ce_pix_out,
    output logic [7:0]    VGA_R,
    output logic [7:0]    VGA_G,
    output logic [7:0]    VGA_B,
    output logic          VGA_HS,
    output logic          VGA_VS,
    output logic          VGA_DE
);

    // Number of copies of a component needed to cover 8 bits.
    localparam int C_REP = (8 + CW - 1) / CW;

    // Replicate the component and keep the top 8 bits.
    function automatic logic [7:0] expand(input logic [CW-1:0] c);
        logic [C_REP*CW-1:0] w_rep;
        w_rep = {C_REP{c}};
        return w_rep[C_REP*CW-1 -: 8];
    endfunction

    // Scale by (8-level)/8 with floor; the product never exceeds 11 bits.
    function automatic logic [7:0] attenuate(input logic [7:0] c, input logic [2:0] lvl);
        logic [10:0] w_prod;
        w_prod = 11'(c) * 11'(4'd8 - {1'b0, lvl});
        return w_prod[10:3];
    endfunction

    // Edge-detect history and per-line scanline state
    logic       old_hs_q, old_vs_q, old_hde_q;
    logic [1:0] line_cnt_q, line_cnt_d;
    logic [2:0] level_q, level_d;
    logic [1:0] phase_q, phase_d;

    // Stage 1
    logic [7:0] r1_q, g1_q, b1_q;
    logic       hs1_q, vs1_q, ce1_q, dark1_q;
    logic       de1_q, de1_d;
    logic [2:0] lvl1_q;

    logic hs_fall, vs_fall, hde, dark;

    assign hs_fall = old_hs_q & ~HSync;
    assign vs_fall = old_vs_q & ~VSync;
    assign hde     = ~HBlank;
    // line_cnt never reaches SL_PERIOD, so an out-of-range phase darkens nothing.
    assign dark    = (level_q != 3'd0) && (line_cnt_q == phase_q);

    // Next-state for line counter, latched settings and data enable
    always_comb begin
        line_cnt_d = line_cnt_q;
        level_d    = level_q;
        phase_d    = phase_q;
        de1_d      = de1_q;
        if (hs_fall) begin
            line_cnt_d = (line_cnt_q == 2'(SL_PERIOD - 1)) ? 2'd0 : line_cnt_q + 2'd1;
            level_d    = sl_level;
            phase_d    = sl_phase;
        end
        // Frame start wins over a coincident line start.
        if (vs_fall) begin
            line_cnt_d = 2'd0;
        end
        // DE follows VBlank only at the start of each active line.
        if (~old_hde_q & hde) begin
            de1_d = ~VBlank;
        end else if (old_hde_q & ~hde) begin
            de1_d = 1'b0;
        end
    end

    // Line tracking state and stage 1: expansion, dark flag and DE capture
    always_ff @(posedge clk_vid) begin
        if (reset) begin
            old_hs_q   <= 1'b0;
            old_vs_q   <= 1'b0;
            old_hde_q  <= 1'b0;
            line_cnt_q <= 2'd0;
            level_q    <= 3'd0;
            phase_q    <= 2'd0;
            r1_q       <= 8'd0;
            g1_q       <= 8'd0;
            b1_q       <= 8'd0;
            hs1_q      <= 1'b0;
            vs1_q      <= 1'b0;
            ce1_q      <= 1'b0;
            dark1_q    <= 1'b0;
            de1_q      <= 1'b0;
            lvl1_q     <= 3'd0;
        end else begin
            old_hs_q   <= HSync;
            old_vs_q   <= VSync;
            old_hde_q  <= hde;
            line_cnt_q <= line_cnt_d;
            level_q    <= level_d;
            phase_q    <= phase_d;
            r1_q       <= expand(R);
            g1_q       <= expand(G);
            b1_q       <= expand(B);
            hs1_q      <= HSync;
            vs1_q      <= VSync;
            ce1_q      <= ce_pix;
            dark1_q    <= dark;
            de1_q      <= de1_d;
            lvl1_q     <= level_q;
        end
    end

    // Stage 2: attenuation and registered outputs
    always_ff @(posedge clk_vid) begin
        if (reset) begin
            VGA_R      <= 8'd0;
            VGA_G      <= 8'd0;
            VGA_B      <= 8'd0;
            VGA_HS     <= 1'b0;
            VGA_VS     <= 1'b0;
            VGA_DE     <= 1'b0;
            ce_pix_out <= 1'b0;
        end else begin
            VGA_R      <= dark1_q ? attenuate(r1_q, lvl1_q) : r1_q;
            VGA_G      <= dark1_q ? attenuate(g1_q, lvl1_q) : g1_q;
            VGA_B      <= dark1_q ? attenuate(b1_q, lvl1_q) : b1_q;
            VGA_HS     <= hs1_q;
            VGA_VS     <= vs1_q;
            VGA_DE     <= de1_q;
            ce_pix_out <= ce1_q;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_video_out_stage.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_video_out_stage
// Description : Scoreboard bench for video_out_stage. Three instances
//               (CW/SL_PERIOD = 4/2, 8/3, 3/2) share one stimulus stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_video_out_stage;

    typedef struct packed {
        logic [7:0] r, g, b;
        logic       hs, vs, de;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1, ce_pix = 1'b0, hs = 1'b0, vs = 1'b0, hb = 1'b1, vb = 1'b1;
    logic [7:0] rin = 8'd0, gin = 8'd0, bin = 8'd0;
    logic [2:0] lvl = 3'd0;
    logic [1:0] ph = 2'd0;

    logic       ce_o [3];
    logic [7:0] vr [3], vg [3], vbo [3];
    logic       vhs [3], vvs [3], vde [3];

    video_out_stage #(.CW(4), .SL_PERIOD(2)) u_a (
        .clk_vid(clk), .reset(reset), .ce_pix(ce_pix),
        .R(rin[3:0]), .G(gin[3:0]), .B(bin[3:0]),
        .HSync(hs), .VSync(vs), .HBlank(hb), .VBlank(vb),
        .sl_level(lvl), .sl_phase(ph),
        .ce_pix_out(ce_o[0]), .VGA_R(vr[0]), .VGA_G(vg[0]), .VGA_B(vbo[0]),
        .VGA_HS(vhs[0]), .VGA_VS(vvs[0]), .VGA_DE(vde[0]));

    video_out_stage #(.CW(8), .SL_PERIOD(3)) u_b (
        .clk_vid(clk), .reset(reset), .ce_pix(ce_pix),
        .R(rin), .G(gin), .B(bin),
        .HSync(hs), .VSync(vs), .HBlank(hb), .VBlank(vb),
        .sl_level(lvl), .sl_phase(ph),
        .ce_pix_out(ce_o[1]), .VGA_R(vr[1]), .VGA_G(vg[1]), .VGA_B(vbo[1]),
        .VGA_HS(vhs[1]), .VGA_VS(vvs[1]), .VGA_DE(vde[1]));

    video_out_stage #(.CW(3), .SL_PERIOD(2)) u_c (
        .clk_vid(clk), .reset(reset), .ce_pix(ce_pix),
        .R(rin[2:0]), .G(gin[2:0]), .B(bin[2:0]),
        .HSync(hs), .VSync(vs), .HBlank(hb), .VBlank(vb),
        .sl_level(lvl), .sl_phase(ph),
        .ce_pix_out(ce_o[2]), .VGA_R(vr[2]), .VGA_G(vg[2]), .VGA_B(vbo[2]),
        .VGA_HS(vhs[2]), .VGA_VS(vvs[2]), .VGA_DE(vde[2]));

    function automatic int cw_of(input int i);
        return (i == 0) ? 4 : (i == 1) ? 8 : 3;
    endfunction
    function automatic int sl_of(input int i);
        return (i == 1) ? 3 : 2;
    endfunction

    // ---------------- reference model ----------------
    exp_t q0[$], q1[$], q2[$];
    int         hcount = 0;          // HSync falls since the last VSync fall
    logic       m_hs = 0, m_vs = 0, m_hde = 0, m_de = 0;
    logic [2:0] m_lvl = 0;
    logic [1:0] m_ph = 0;

    // Bit i of the 8-bit result (MSB first) is bit (i mod cw) of c, MSB first.
    function automatic logic [7:0] m_expand(input logic [7:0] c, input int cw);
        logic [7:0] res;
        res = 8'd0;
        for (int i = 0; i < 8; i++) res[7-i] = c[cw - 1 - (i % cw)];
        return res;
    endfunction

    function automatic logic [7:0] m_colour(input logic [7:0] c, input int cw,
                                            input bit dark, input int level);
        int c8;
        c8 = int'(m_expand(c, cw));
        if (dark) return 8'((c8 * (8 - level)) / 8);
        return 8'(c8);
    endfunction

    // Advance the model by one clock edge using the inputs now being driven.
    task automatic step();
        exp_t e;
        bit   dark, hfall, vfall;
        if (reset) begin
            hcount = 0; m_hs = 0; m_vs = 0; m_hde = 0; m_de = 0; m_lvl = 0; m_ph = 0;
            return;
        end
        if (!hb && !m_hde)      m_de = ~vb;
        else if (hb && m_hde)   m_de = 1'b0;
        for (int i = 0; i < 3; i++) begin
            dark = (m_lvl != 0) && ((hcount % sl_of(i)) == int'(m_ph));
            e.r  = m_colour(rin, cw_of(i), dark, int'(m_lvl));
            e.g  = m_colour(gin, cw_of(i), dark, int'(m_lvl));
            e.b  = m_colour(bin, cw_of(i), dark, int'(m_lvl));
            e.hs = hs; e.vs = vs; e.de = m_de;
            if (ce_pix) begin
                if (i == 0) q0.push_back(e);
                else if (i == 1) q1.push_back(e);
                else q2.push_back(e);
            end
        end
        hfall = m_hs && !hs;
        vfall = m_vs && !vs;
        if (vfall)      hcount = 0;
        else if (hfall) hcount = hcount + 1;
        if (hfall) begin m_lvl = lvl; m_ph = ph; end
        m_hs = hs; m_vs = vs; m_hde = ~hb;
    endtask

    // ---------------- stimulus ----------------
    logic       cur_rst = 1'b1;
    logic [2:0] cur_lvl = 3'd0;
    logic [1:0] cur_ph  = 3'd0;
    bit         rnd_ce  = 1'b0;

    task automatic cyc(input logic h, input logic v, input logic hbk, input logic vbk,
                       input logic c, input logic [7:0] r, input logic [7:0] g,
                       input logic [7:0] b);
        @(posedge clk);
        #1;
        reset = cur_rst; hs = h; vs = v; hb = hbk; vb = vbk; ce_pix = c;
        rin = r; gin = g; bin = b; lvl = cur_lvl; ph = cur_ph;
        step();
    endtask

    function automatic logic pick_ce();
        return rnd_ce ? ($urandom_range(0, 3) != 0) : 1'b1;
    endfunction

    // vmode: 0 no VSync, 1 VSync falls with HSync, 2 VSync falls one clock later.
    task automatic line(input int act, input int vmode, input logic vbk, input bit vflip,
                        input bit rnd_col, input logic [7:0] col, input int lvl_mid);
        logic [7:0] r, g, b;
        logic       vbc;
        vbc = vbk;
        for (int k = 0; k < 2; k++)
            cyc(1'b1, vmode != 0, 1'b1, vbc, pick_ce(), 8'($urandom), 8'($urandom), 8'($urandom));
        cyc(1'b0, vmode == 2, 1'b1, vbc, pick_ce(), 8'($urandom), 8'($urandom), 8'($urandom));
        cyc(1'b0, 1'b0, 1'b1, vbc, pick_ce(), 8'($urandom), 8'($urandom), 8'($urandom));
        for (int k = 0; k < act; k++) begin
            if (k == act / 2) begin
                if (lvl_mid >= 0) cur_lvl = 3'(lvl_mid);
                if (vflip) vbc = ~vbc;
            end
            r = rnd_col ? 8'($urandom) : col;
            g = rnd_col ? 8'($urandom) : col;
            b = rnd_col ? 8'($urandom) : col;
            cyc(1'b0, 1'b0, 1'b0, vbc, pick_ce(), r, g, b);
        end
        for (int k = 0; k < 2; k++)
            cyc(1'b0, 1'b0, 1'b1, vbc, pick_ce(), 8'($urandom), 8'($urandom), 8'($urandom));
    endtask

    task automatic do_reset(input int n);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        cur_rst = 1'b1;
        for (int k = 0; k < n; k++)
            cyc(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                8'($urandom), 8'($urandom), 8'($urandom));
        cur_rst = 1'b0;
    endtask

    // ---------------- monitor ----------------
    int   n_chk = 0, n_fail = 0;
    logic rst_seen = 1'b0;
    bit   end_chk = 1'b0, end_done = 1'b0;

    always @(posedge clk) rst_seen <= reset;

    always @(negedge clk) begin
        exp_t e, a;
        bit   have;
        for (int i = 0; i < 3; i++) begin
            a = '{r: vr[i], g: vg[i], b: vbo[i], hs: vhs[i], vs: vvs[i], de: vde[i]};
            if (rst_seen) begin
                n_chk++;
                if (a != '0 || ce_o[i] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL reset[%0d]: got outputs=%h ce=%b, need all 0", i, a, ce_o[i]);
                end
            end else if (ce_o[i] === 1'b1) begin
                have = 1'b0;
                if (i == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
                if (i == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
                if (i == 2 && q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
                n_chk++;
                if (!have) begin
                    n_fail++;
                    $display("FAIL pix[%0d] @%0t: ce_pix_out=1, need no pixel pending", i, $time);
                end else if (a !== e) begin
                    n_fail++;
                    $display("FAIL pix[%0d] @%0t: got r=%h g=%h b=%h hs=%b vs=%b de=%b, need r=%h g=%h b=%h hs=%b vs=%b de=%b",
                             i, $time, a.r, a.g, a.b, a.hs, a.vs, a.de, e.r, e.g, e.b, e.hs, e.vs, e.de);
                end
            end
        end
        if (end_chk && !end_done) begin
            end_done = 1'b1;
            for (int i = 0; i < 3; i++) begin
                int left;
                left = (i == 0) ? q0.size() : (i == 1) ? q1.size() : q2.size();
                n_chk++;
                if (left != 0) begin
                    n_fail++;
                    $display("FAIL drain[%0d]: got %0d pixels never output, need 0", i, left);
                end
            end
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        do_reset(3);
        // Plain pass-through, 0xA -> 0xAA at CW=4
        cur_lvl = 0; cur_ph = 0;
        line(8, 1, 1'b0, 0, 0, 8'hAA, -1);
        line(8, 0, 1'b0, 0, 0, 8'hAA, -1);
        // Alternate-line darkening, level 4 then level 7
        cur_lvl = 4; cur_ph = 1;
        for (int k = 0; k < 4; k++) line(6, (k == 0) ? 1 : 0, 1'b0, 0, 0, 8'hFF, -1);
        cur_lvl = 7;
        for (int k = 0; k < 4; k++) line(6, 0, 1'b0, 0, 0, 8'hFF, -1);
        // Three-line pattern at level 2, phase 2, then restart by VSync
        cur_lvl = 2; cur_ph = 2;
        for (int k = 0; k < 6; k++) line(6, 0, 1'b0, 0, 0, 8'h80, -1);
        line(6, 2, 1'b0, 0, 0, 8'h80, -1);
        for (int k = 0; k < 3; k++) line(6, 0, 1'b0, 0, 0, 8'h80, -1);
        // Level changed mid-line
        cur_lvl = 4; cur_ph = 0;
        line(10, 0, 1'b0, 0, 0, 8'hFF, 1);
        for (int k = 0; k < 3; k++) line(6, 0, 1'b0, 0, 0, 8'hFF, -1);
        // Coincident HSync/VSync falls, out-of-range phase
        cur_lvl = 5; cur_ph = 0;
        for (int k = 0; k < 3; k++) line(6, 1, 1'b0, 0, 0, 8'hC3, -1);
        cur_ph = 3;
        for (int k = 0; k < 3; k++) line(6, 0, 1'b0, 0, 0, 8'hFF, -1);
        // VBlank flipping mid-line, then vertical blank lines
        cur_ph = 0;
        line(8, 0, 1'b0, 1, 0, 8'h5A, -1);
        line(8, 0, 1'b1, 1, 0, 8'h5A, -1);
        line(8, 0, 1'b1, 0, 0, 8'h5A, -1);
        // Mid-frame reset
        do_reset(2);
        cur_lvl = 6; cur_ph = 0;
        for (int k = 0; k < 3; k++) line(6, 0, 1'b0, 0, 0, 8'hFF, -1);
        // Randomised frames
        rnd_ce = 1'b1;
        for (int f = 0; f < 8; f++) begin
            for (int k = 0; k < 6; k++) begin
                cur_lvl = 3'($urandom);
                cur_ph  = 2'($urandom);
                line($urandom_range(4, 16),
                     (k == 0) ? int'($urandom_range(1, 2)) : 0,
                     1'($urandom_range(0, 4) == 0),
                     1'($urandom_range(0, 3) == 0),
                     1'b1, 8'h00,
                     ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : -1);
            end
        end
        // Drain the pipeline and settle the scoreboard
        rnd_ce = 1'b0;
        for (int k = 0; k < 4; k++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        end_chk = 1'b1;
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        if (!end_done) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: got no final scoreboard check, need one");
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
